store_buffer: RTL

- Committed-store queue between the EX-stage store path and the data-memory write port.
- Accepts word-aligned store requests (address, lane-aligned data, per-byte write enables) in program order and drains them to memory with a valid/ready handshake.
- Gives the load path a combinational byte-granular forwarding lookup so younger loads see buffered stores.
- Reports empty for FENCE/AMO/LR ordering.

---
 rtl/store_buffer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | store_buffer: in-order committed-store queue with byte-level load forward |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module store_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enq_valid,
  output logic                     o_enq_ready,
  input  logic [XLEN-1:0]          i_enq_address,
  input  logic [XLEN-1:0]          i_enq_write_data,
  input  logic [3:0]               i_enq_byte_write_enable,
  output logic                     o_mem_valid,
  input  logic                     i_mem_ready,
  output logic [XLEN-1:0]          o_mem_address,
  output logic [XLEN-1:0]          o_mem_write_data,
  output logic [3:0]               o_mem_byte_write_enable,
  input  logic [XLEN-1:0]          i_load_address,
  input  logic [3:0]               i_load_byte_mask,
  output logic                     o_fwd_hit,
  output logic [XLEN-1:0]          o_fwd_data,
  output logic                     o_fwd_conflict,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam int c_AW = XLEN - 2;
  localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

  logic [c_AW-1:0] r_addr [DEPTH];
  logic [XLEN-1:0] r_data [DEPTH];
  logic [3:0]      r_be   [DEPTH];
  logic [c_PW-1:0] r_head;
  logic [c_PW-1:0] r_tail;
  logic [c_CW-1:0] r_count;

  logic            w_enq_fire;
  logic            w_enq_write;
  logic            w_deq;
  logic [c_PW-1:0] w_idx;
  logic [3:0]      w_covered;
  logic [31:0]     w_merged;
  logic            w_unused_bits;

  assign o_enq_ready = (r_count != c_FULL);
  assign o_mem_valid = (r_count != '0);
  assign o_empty     = (r_count == '0);
  assign o_count     = r_count;

  assign w_enq_fire  = i_enq_valid && o_enq_ready;
  // All-zero strobes (failed SC, etc.) are accepted but never occupy a slot.
  assign w_enq_write = w_enq_fire && (i_enq_byte_write_enable != 4'b0000);
  assign w_deq       = o_mem_valid && i_mem_ready;

  assign o_mem_address           = {r_addr[r_head], 2'b00};
  assign o_mem_write_data        = r_data[r_head];
  assign o_mem_byte_write_enable = r_be[r_head];

  assign w_unused_bits = ^{i_enq_address[1:0], i_load_address[1:0]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq_write) r_tail <= r_tail + c_PW'(1);
      if (w_deq)       r_head <= r_head + c_PW'(1);
      case ({w_enq_write, w_deq})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_enq_write) begin
      r_addr[r_tail] <= i_enq_address[XLEN-1:2];
      r_data[r_tail] <= i_enq_write_data;
      r_be[r_tail]   <= i_enq_byte_write_enable;
    end
  end

  // Walk oldest to youngest so later matches overwrite earlier ones per byte.
  always_comb begin
    w_covered = '0;
    w_merged  = '0;
    w_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + c_PW'(k);
      if ((c_CW'(k) < r_count) && (r_addr[w_idx] == i_load_address[XLEN-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (r_be[w_idx][b]) begin
            w_covered[b]       = 1'b1;
            w_merged[8*b +: 8] = r_data[w_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign o_fwd_hit      = (i_load_byte_mask != 4'b0000) &&
                          ((i_load_byte_mask & ~w_covered) == 4'b0000);
  assign o_fwd_conflict = ((i_load_byte_mask & w_covered) != 4'b0000) && !o_fwd_hit;

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign o_fwd_data[8*b +: 8] = (w_covered[b] && i_load_byte_mask[b]) ?
                                  w_merged[8*b +: 8] : 8'h00;
  end

  if (XLEN > 32) begin : g_upper
    assign o_fwd_data[XLEN-1:32] = '0;
  end

endmodule
`default_nettype wire
